// File: rtl/uart_fifo.sv
// UART with byte-wide TX and RX FIFOs behind a simple request/response register bus.
//   clk, rst          : single rising-edge clock, synchronous active-high reset
//   req_i/we_i/addr_i : bus strobe, direction and byte offset ([7:0] decoded)
//   data_i/sel_i      : write data and byte enables
//   data_o            : read data, registered one cycle after a read strobe, else 0
//   tx_pin/rx_pin     : serial out (idles high) / asynchronous serial in
//   irq_o             : level interrupt (RX data or error flags, TX drained)
module uart_fifo #(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  input  logic [3:0]  sel_i,
  input  logic        we_i,
  output logic [31:0] data_o,
  output logic        tx_pin,
  input  logic        rx_pin,
  output logic        irq_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FifoFull = CW'(FIFO_DEPTH);
  localparam logic [15:0] BaudRst = 16'(CLK_HZ / 115200);

  typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;
  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop} rx_state_e;

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic [7:0] reg_addr;
  logic       bus_wr, bus_rd;
  logic       wr_ctrl, wr_stat, wr_baud, wr_txd, rd_rxd;

  assign reg_addr = addr_i[7:0];
  assign bus_wr   = req_i & we_i;
  assign bus_rd   = req_i & ~we_i;
  assign wr_ctrl  = bus_wr && (reg_addr == 8'h00);
  assign wr_stat  = bus_wr && (reg_addr == 8'h04);
  assign wr_baud  = bus_wr && (reg_addr == 8'h08);
  assign wr_txd   = bus_wr && (reg_addr == 8'h0C);
  assign rd_rxd   = bus_rd && (reg_addr == 8'h10);

  logic unused_bits;
  assign unused_bits = ^{addr_i[31:8], data_i[31:16], sel_i[3:2]};

  // ---------------------------------------------------------------------------
  // Registers and FIFO state
  // ---------------------------------------------------------------------------
  logic [8:0]    ctrl_q, ctrl_d;
  logic [15:0]   baud_q, baud_d;
  logic          ovr_q, ovr_d, perr_q, perr_d, ferr_q, ferr_d;
  logic [31:0]   data_q, data_d;

  logic [7:0]    tx_mem_q [FIFO_DEPTH];
  logic [AW-1:0] tx_wptr_q, tx_rptr_q;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic          tx_push, tx_pop;

  logic [7:0]    rx_mem_q [FIFO_DEPTH];
  logic [AW-1:0] rx_wptr_q, rx_rptr_q;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic          rx_push, rx_push_req, rx_pop;

  logic [7:0]    tx_head, rx_head;
  logic          tx_full, rx_nempty, tx_busy;

  tx_state_e     tx_state_q, tx_state_d;
  logic [15:0]   tx_tick_q, tx_tick_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic [4:0]    tx_cfg_q, tx_cfg_d;  // {two stop, odd, parity en, data bits[1:0]}
  logic          tx_par_q, tx_par_d;

  rx_state_e     rx_state_q, rx_state_d;
  logic [15:0]   rx_tick_q, rx_tick_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic [4:0]    rx_cfg_q, rx_cfg_d;
  logic          rx_perr_q, rx_perr_d;  // parity mismatch pending until the stop sample
  logic          rx_s1_q, rx_s2_q, rx_prev_q;
  logic          perr_set, ferr_set, ovr_set;

  assign tx_head   = tx_mem_q[tx_rptr_q];
  assign rx_head   = rx_mem_q[rx_rptr_q];
  assign tx_full   = (tx_cnt_q == FifoFull);
  assign rx_nempty = (rx_cnt_q != '0);
  assign tx_busy   = (tx_cnt_q != '0) || (tx_state_q != TxIdle);

  // A push into a full FIFO is accepted only when a pop happens in the same cycle.
  assign tx_push = wr_txd & sel_i[0] & (~tx_full | tx_pop);
  assign rx_pop  = rd_rxd & rx_nempty;
  assign rx_push = rx_push_req & ((rx_cnt_q != FifoFull) | rx_pop);
  assign ovr_set = rx_push_req & ~rx_push;

  always_comb begin
    tx_cnt_d = tx_cnt_q;
    case ({tx_push, tx_pop})
      2'b10:   tx_cnt_d = tx_cnt_q + 1'b1;
      2'b01:   tx_cnt_d = tx_cnt_q - 1'b1;
      default: tx_cnt_d = tx_cnt_q;
    endcase
    rx_cnt_d = rx_cnt_q;
    case ({rx_push, rx_pop})
      2'b10:   rx_cnt_d = rx_cnt_q + 1'b1;
      2'b01:   rx_cnt_d = rx_cnt_q - 1'b1;
      default: rx_cnt_d = rx_cnt_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Register writes, W1C flags and read data
  // ---------------------------------------------------------------------------
  always_comb begin
    logic [2:0] w1c;
    ctrl_d = ctrl_q;
    baud_d = baud_q;
    if (wr_ctrl && sel_i[0]) ctrl_d[7:0]  = data_i[7:0];
    if (wr_ctrl && sel_i[1]) ctrl_d[8]    = data_i[8];
    if (wr_baud && sel_i[0]) baud_d[7:0]  = data_i[7:0];
    if (wr_baud && sel_i[1]) baud_d[15:8] = data_i[15:8];

    w1c = (wr_stat && sel_i[0]) ? data_i[5:3] : 3'b000;
    // Hardware set takes priority over a same-cycle clear.
    ovr_d  = (ovr_q  & ~w1c[0]) | ovr_set;
    perr_d = (perr_q & ~w1c[1]) | perr_set;
    ferr_d = (ferr_q & ~w1c[2]) | ferr_set;

    data_d = 32'h0;
    if (bus_rd) begin
      case (reg_addr)
        8'h00: data_d = {23'h0, ctrl_q};
        8'h04: data_d = {8'h0, 8'(rx_cnt_q), 8'(tx_cnt_q), 2'b00, ferr_q, perr_q, ovr_q,
                         tx_full, rx_nempty, tx_busy};
        8'h08: data_d = {16'h0, baud_q};
        8'h10: data_d = rx_nempty ? {24'h0, rx_head} : 32'h0;
        default: data_d = 32'h0;
      endcase
    end
  end

  assign data_o = data_q;
  assign irq_o  = (ctrl_q[7] & (rx_nempty | ovr_q | perr_q | ferr_q)) | (ctrl_q[8] & ~tx_busy);

  // ---------------------------------------------------------------------------
  // TX FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    logic [7:0] mask;
    tx_state_d = tx_state_q;
    tx_tick_d  = tx_tick_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_cfg_d   = tx_cfg_q;
    tx_par_d   = tx_par_q;
    tx_pop     = 1'b0;
    mask       = 8'hFF >> (2'd3 - ctrl_q[3:2]);
    unique case (tx_state_q)
      TxIdle: begin
        if (ctrl_q[0] && (tx_cnt_q != '0)) begin
          tx_pop     = 1'b1;
          tx_shift_d = tx_head;
          tx_cfg_d   = ctrl_q[6:2];
          tx_par_d   = (^(tx_head & mask)) ^ ctrl_q[5];
          tx_tick_d  = baud_q;
          tx_bit_d   = 3'd0;
          tx_state_d = TxStart;
        end
      end
      TxStart: begin
        if (tx_tick_q == '0) begin
          tx_tick_d  = baud_q;
          tx_state_d = TxData;
        end else begin
          tx_tick_d = tx_tick_q - 16'd1;
        end
      end
      TxData: begin
        if (tx_tick_q == '0) begin
          tx_tick_d  = baud_q;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          if (tx_bit_q == (3'd4 + {1'b0, tx_cfg_q[1:0]})) begin
            tx_bit_d   = 3'd0;
            tx_state_d = tx_cfg_q[2] ? TxParity : TxStop;
          end else begin
            tx_bit_d = tx_bit_q + 3'd1;
          end
        end else begin
          tx_tick_d = tx_tick_q - 16'd1;
        end
      end
      TxParity: begin
        if (tx_tick_q == '0) begin
          tx_tick_d  = baud_q;
          tx_state_d = TxStop;
        end else begin
          tx_tick_d = tx_tick_q - 16'd1;
        end
      end
      TxStop: begin
        if (tx_tick_q == '0) begin
          if (tx_cfg_q[4] && (tx_bit_q == 3'd0)) begin
            tx_bit_d  = 3'd1;
            tx_tick_d = baud_q;
          end else begin
            tx_state_d = TxIdle;
          end
        end else begin
          tx_tick_d = tx_tick_q - 16'd1;
        end
      end
      default: tx_state_d = TxIdle;
    endcase
  end

  always_comb begin
    unique case (tx_state_q)
      TxStart:  tx_pin = 1'b0;
      TxData:   tx_pin = tx_shift_q[0];
      TxParity: tx_pin = tx_par_q;
      default:  tx_pin = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // RX FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_tick_d   = rx_tick_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    rx_cfg_d    = rx_cfg_q;
    rx_perr_d   = rx_perr_q;
    rx_push_req = 1'b0;
    perr_set    = 1'b0;
    ferr_set    = 1'b0;
    if (!ctrl_q[1]) begin
      rx_state_d = RxIdle;
    end else begin
      unique case (rx_state_q)
        RxIdle: begin
          if (rx_prev_q && !rx_s2_q) begin
            rx_tick_d  = {1'b0, baud_q[15:1]};
            rx_cfg_d   = ctrl_q[6:2];
            rx_shift_d = 8'h0;
            rx_bit_d   = 3'd0;
            rx_perr_d  = 1'b0;
            rx_state_d = RxStart;
          end
        end
        RxStart: begin
          if (rx_tick_q == '0) begin
            rx_tick_d  = baud_q;
            rx_state_d = rx_s2_q ? RxIdle : RxData;
          end else begin
            rx_tick_d = rx_tick_q - 16'd1;
          end
        end
        RxData: begin
          if (rx_tick_q == '0) begin
            rx_tick_d = baud_q;
            rx_shift_d[rx_bit_q] = rx_s2_q;
            if (rx_bit_q == (3'd4 + {1'b0, rx_cfg_q[1:0]})) begin
              rx_state_d = rx_cfg_q[2] ? RxParity : RxStop;
            end else begin
              rx_bit_d = rx_bit_q + 3'd1;
            end
          end else begin
            rx_tick_d = rx_tick_q - 16'd1;
          end
        end
        RxParity: begin
          if (rx_tick_q == '0) begin
            rx_tick_d  = baud_q;
            rx_perr_d  = rx_s2_q != ((^rx_shift_q) ^ rx_cfg_q[3]);
            rx_state_d = RxStop;
          end else begin
            rx_tick_d = rx_tick_q - 16'd1;
          end
        end
        RxStop: begin
          if (rx_tick_q == '0) begin
            rx_push_req = 1'b1;
            ferr_set    = ~rx_s2_q;
            perr_set    = rx_perr_q;
            rx_state_d  = RxIdle;
          end else begin
            rx_tick_d = rx_tick_q - 16'd1;
          end
        end
        default: rx_state_d = RxIdle;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wptr_q] <= data_i[7:0];
    if (rx_push) rx_mem_q[rx_wptr_q] <= rx_shift_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q     <= '0;
      baud_q     <= BaudRst;
      ovr_q      <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      data_q     <= '0;
      tx_wptr_q  <= '0;
      tx_rptr_q  <= '0;
      tx_cnt_q   <= '0;
      rx_wptr_q  <= '0;
      rx_rptr_q  <= '0;
      rx_cnt_q   <= '0;
      tx_state_q <= TxIdle;
      tx_tick_q  <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_cfg_q   <= '0;
      tx_par_q   <= 1'b0;
      rx_state_q <= RxIdle;
      rx_tick_q  <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_cfg_q   <= '0;
      rx_perr_q  <= 1'b0;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
    end else begin
      ctrl_q     <= ctrl_d;
      baud_q     <= baud_d;
      ovr_q      <= ovr_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      data_q     <= data_d;
      if (tx_push) tx_wptr_q <= tx_wptr_q + 1'b1;
      if (tx_pop)  tx_rptr_q <= tx_rptr_q + 1'b1;
      tx_cnt_q   <= tx_cnt_d;
      if (rx_push) rx_wptr_q <= rx_wptr_q + 1'b1;
      if (rx_pop)  rx_rptr_q <= rx_rptr_q + 1'b1;
      rx_cnt_q   <= rx_cnt_d;
      tx_state_q <= tx_state_d;
      tx_tick_q  <= tx_tick_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_cfg_q   <= tx_cfg_d;
      tx_par_q   <= tx_par_d;
      rx_state_q <= rx_state_d;
      rx_tick_q  <= rx_tick_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_cfg_q   <= rx_cfg_d;
      rx_perr_q  <= rx_perr_d;
      rx_s1_q    <= rx_pin;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
    end
  end

endmodule

// File: tb/tb_uart_fifo.sv
module tb_uart_fifo;

  localparam int unsigned Depth   = 4;
  localparam int unsigned BaudDef = 50000000 / 115200;

  localparam logic [31:0] ACtrl = 32'h00;
  localparam logic [31:0] AStat = 32'h04;
  localparam logic [31:0] ABaud = 32'h08;
  localparam logic [31:0] ATxd  = 32'h0C;
  localparam logic [31:0] ARxd  = 32'h10;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  sel;
  logic        we;
  logic [31:0] rdata;
  logic        tx_pin;
  logic        rx_pin;
  logic        irq;
  logic        loop_en;
  logic        rx_drv;

  int checks = 0;
  int errors = 0;

  bit          exp_bits[$];
  logic [7:0]  exp_q[$];

  assign rx_pin = loop_en ? tx_pin : rx_drv;

  always #5 clk = ~clk;

  uart_fifo #(
    .CLK_HZ    (50000000),
    .FIFO_DEPTH(Depth)
  ) u_dut (
    .clk   (clk),
    .rst   (rst),
    .req_i (req),
    .addr_i(addr),
    .data_i(wdata),
    .sel_i (sel),
    .we_i  (we),
    .data_o(rdata),
    .tx_pin(tx_pin),
    .rx_pin(rx_pin),
    .irq_o (irq)
  );

  initial begin
    #2ms;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = a; wdata = d; sel = s;
    @(negedge clk);
    req = 1'b0; we = 1'b0;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = a; sel = 4'hF;
    @(negedge clk);
    req = 1'b0;
    d = rdata;
  endtask

  // Line-level picture of one frame: start, N data bits LSB first, optional parity, stop(s).
  function automatic void build_frame(input logic [7:0] d, input logic [1:0] nb, input logic pe,
                                      input logic odd, input logic two);
    int  n;
    logic p;
    n = 5 + int'(nb);
    p = odd;
    exp_bits.delete();
    exp_bits.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      exp_bits.push_back(d[i]);
      p = p ^ d[i];
    end
    if (pe) exp_bits.push_back(p);
    exp_bits.push_back(1'b1);
    if (two) exp_bits.push_back(1'b1);
  endfunction

  function automatic logic [7:0] data_mask(input logic [1:0] nb);
    logic [7:0] m;
    m = 8'h00;
    for (int i = 0; i < 5 + int'(nb); i++) m[i] = 1'b1;
    return m;
  endfunction

  // Waits for the start bit, then compares tx_pin cycle by cycle with exp_bits.
  task automatic check_tx_frame(input int baud);
    int w;
    w = 0;
    @(negedge clk);
    while (tx_pin !== 1'b0 && w < 30) begin
      @(negedge clk);
      w++;
    end
    check("tx_start_seen", 32'(w < 30), 32'd1);
    if (w < 30) begin
      for (int i = 0; i < exp_bits.size(); i++) begin
        for (int c = 0; c <= baud; c++) begin
          if (!(i == 0 && c == 0)) @(negedge clk);
          check("tx_line", 32'(tx_pin), 32'(exp_bits[i]));
        end
      end
    end
  endtask

  task automatic drive_rx_frame(input int baud);
    for (int i = 0; i < exp_bits.size(); i++) begin
      rx_drv = exp_bits[i];
      repeat (baud + 1) @(negedge clk);
    end
    rx_drv = 1'b1;
  endtask

  initial begin
    logic [31:0] d;
    logic [7:0]  b;
    logic [1:0]  nb;
    logic        pe, odd, two;
    int          baud;

    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; sel = '0;
    loop_en = 1'b0; rx_drv = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx_pin", 32'(tx_pin), 32'd1);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_data_o", rdata, 32'd0);
    rst = 1'b0;
    bus_rd(ACtrl, d); check("rst_ctrl", d, 32'd0);
    bus_rd(AStat, d); check("rst_status", d, 32'd0);
    bus_rd(ABaud, d); check("rst_baud", d, BaudDef);
    @(negedge clk);
    check("idle_data_o", rdata, 32'd0);

    // Byte lanes, unmapped reads, TX-empty interrupt.
    bus_wr(ABaud, 32'h0000_1234, 4'hF);
    bus_wr(ABaud, 32'h0000_ABCD, 4'h1);
    bus_rd(ABaud, d); check("baud_lane", d, 32'h12CD);
    bus_rd(32'h14, d); check("unmapped", d, 32'd0);
    bus_rd(ATxd, d); check("txdata_read", d, 32'd0);
    bus_wr(ACtrl, 32'h0000_0100, 4'h2);
    @(negedge clk);
    check("irq_tx_empty", 32'(irq), 32'd1);

    // Fixed 8N1 0x55 waveform at BAUD=4.
    bus_wr(ABaud, 32'd4, 4'hF);
    bus_wr(ACtrl, 32'h0F, 4'hF);
    bus_wr(ATxd, 32'h55, 4'h1);
    build_frame(8'h55, 2'b11, 1'b0, 1'b0, 1'b0);
    check_tx_frame(4);
    bus_rd(AStat, d); check("tx_done_busy", 32'(d[0]), 32'd0);

    // Random formats in loopback: waveform and received byte.
    loop_en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      nb = 2'($urandom_range(0, 3)); pe = 1'($urandom); odd = 1'($urandom);
      two = 1'($urandom); baud = int'($urandom_range(3, 9)); b = 8'($urandom);
      bus_wr(ABaud, 32'(baud), 4'hF);
      bus_wr(ACtrl, {25'd0, two, odd, pe, nb, 2'b11}, 4'hF);
      bus_wr(ATxd, {24'd0, b}, 4'h1);
      build_frame(b, nb, pe, odd, two);
      check_tx_frame(baud);
      repeat (3) @(negedge clk);
      bus_rd(ARxd, d); check("loop_rx_byte", d, {24'd0, b & data_mask(nb)});
      bus_rd(AStat, d); check("loop_rx_flags", {d[23:16], 5'd0, d[5:3]}, 32'd0);
    end

    // 7E2 back-to-back frames.
    bus_wr(ABaud, 32'd4, 4'hF);
    bus_wr(ACtrl, 32'h5B, 4'hF);
    bus_wr(ATxd, 32'h41, 4'h1);
    bus_wr(ATxd, 32'h7F, 4'h1);
    repeat (140) @(negedge clk);
    bus_rd(ARxd, d); check("7e2_first", d, 32'h41);
    bus_rd(ARxd, d); check("7e2_second", d, 32'h7F);
    bus_rd(AStat, d); check("7e2_flags", 32'(d[5:3]), 32'd0);

    // TX full with transmitter disabled: extra writes and sel[0]=0 writes are dropped.
    bus_wr(ACtrl, 32'h0E, 4'hF);
    exp_q.delete();
    bus_wr(ATxd, 32'hEE, 4'hE);
    for (int k = 0; k < Depth + 1; k++) begin
      b = 8'($urandom);
      bus_wr(ATxd, {24'd0, b}, 4'h1);
      if (exp_q.size() < Depth) exp_q.push_back(b);
    end
    bus_rd(AStat, d);
    check("txfull_count", 32'(d[15:8]), 32'(exp_q.size()));
    check("txfull_flag", 32'(d[2:0]), 32'b101);
    bus_wr(ACtrl, 32'h0F, 4'hF);
    repeat (Depth * 52 + 20) @(negedge clk);
    while (exp_q.size() > 0) begin
      bus_rd(ARxd, d); check("txfull_order", d, {24'd0, exp_q.pop_front()});
    end

    // RX overrun: five frames, no reads.
    exp_q.delete();
    for (int k = 0; k < Depth + 1; k++) begin
      b = 8'($urandom);
      bus_wr(ATxd, {24'd0, b}, 4'h1);
      exp_q.push_back(b);
    end
    repeat ((Depth + 1) * 52 + 40) @(negedge clk);
    bus_rd(AStat, d);
    check("ovr_rx_count", 32'(d[23:16]), Depth);
    check("ovr_flag", 32'(d[3]), 32'd1);
    for (int k = 0; k < Depth; k++) begin
      bus_rd(ARxd, d); check("ovr_order", d, {24'd0, exp_q.pop_front()});
    end
    bus_rd(ARxd, d); check("rx_empty_read", d, 32'd0);
    bus_wr(AStat, 32'h08, 4'h1);
    bus_rd(AStat, d); check("ovr_cleared", 32'(d[3]), 32'd0);

    // Glitch on rx_pin is a false start; a real frame afterwards is received.
    loop_en = 1'b0; rx_drv = 1'b1;
    bus_wr(ABaud, 32'd8, 4'hF);
    bus_wr(ACtrl, 32'h0E, 4'hF);
    @(negedge clk); rx_drv = 1'b0;
    @(negedge clk); rx_drv = 1'b1;
    repeat (20) @(negedge clk);
    bus_rd(AStat, d); check("glitch_status", d, 32'd0);
    build_frame(8'hC3, 2'b11, 1'b0, 1'b0, 1'b0);
    drive_rx_frame(8);
    repeat (5) @(negedge clk);
    bus_rd(ARxd, d); check("after_glitch_byte", d, 32'hC3);

    // 8E1 0x01 with wrong parity bit.
    bus_wr(ABaud, 32'd7, 4'hF);
    bus_wr(ACtrl, 32'h9E, 4'hF);
    build_frame(8'h01, 2'b11, 1'b1, 1'b0, 1'b0);
    exp_bits[9] = 1'b0;
    drive_rx_frame(7);
    repeat (5) @(negedge clk);
    bus_rd(AStat, d);
    check("perr_flags", 32'(d[5:3]), 32'b010);
    check("perr_rx_count", 32'(d[23:16]), 32'd1);
    check("perr_irq", 32'(irq), 32'd1);
    bus_rd(ARxd, d); check("perr_byte", d, 32'h01);
    check("perr_irq_flag_only", 32'(irq), 32'd1);
    bus_wr(AStat, 32'h10, 4'h1);
    @(negedge clk);
    check("perr_irq_cleared", 32'(irq), 32'd0);

    // Reset in the middle of a frame.
    bus_wr(ABaud, 32'd4, 4'hF);
    bus_wr(ACtrl, 32'h0F, 4'hF);
    bus_wr(ATxd, 32'hA5, 4'h1);
    bus_wr(ATxd, 32'h3C, 4'h1);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midframe_rst_tx_pin", 32'(tx_pin), 32'd1);
    rst = 1'b0;
    bus_rd(AStat, d); check("midframe_rst_status", d, 32'd0);
    bus_rd(ABaud, d); check("midframe_rst_baud", d, BaudDef);
    bus_rd(ACtrl, d); check("midframe_rst_ctrl", d, 32'd0);
    repeat (10) @(negedge clk);
    check("midframe_rst_idle", 32'(tx_pin), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
